// File: rtl/fetch_redirect_unit.sv
// fetch_redirect_unit: fetch-stage PC generator.
// Owns the fetch PC and fetch epoch. Arbitrates backend recovery, decode
// redirects and BTB predictions. A redirect that arrives while the I-cache
// is stalled is parked in pending_pc and applied once the stall clears.
module fetch_redirect_unit #(
  parameter int                     PC_WIDTH        = 32,
  parameter logic [PC_WIDTH-1:0]    RESET_PC        = PC_WIDTH'(32'h0000_1000),
  parameter int                     FETCH_WIDTH     = 2,
  parameter int                     INSN_BYTE_WIDTH = 4,
  parameter int                     EPOCH_WIDTH     = 2,
  parameter int                     CNT_WIDTH       = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fetchStall,
  input  logic                   backendRecover,
  input  logic [PC_WIDTH-1:0]    backendRecoverPC,
  input  logic                   decodeRedirect,
  input  logic [PC_WIDTH-1:0]    decodeRedirectPC,
  input  logic [EPOCH_WIDTH-1:0] decodeRedirectEpoch,
  input  logic                   predTaken,
  input  logic [PC_WIDTH-1:0]    predAddr,
  output logic [PC_WIDTH-1:0]    fetchPC,
  output logic                   fetchValid,
  output logic [EPOCH_WIDTH-1:0] fetchEpoch,
  output logic                   redirectAccepted,
  output logic [CNT_WIDTH-1:0]   decodeRedirectCnt,
  output logic [CNT_WIDTH-1:0]   backendRecoverCnt
);

  // Bytes covered by one fetch group; the sequential PC steps by this
  // amount from the group-aligned address.
  localparam int                  GROUP_BYTES = FETCH_WIDTH * INSN_BYTE_WIDTH;
  localparam logic [PC_WIDTH-1:0] GROUP_MASK  = PC_WIDTH'(GROUP_BYTES - 1);
  localparam logic [PC_WIDTH-1:0] GROUP_STEP  = PC_WIDTH'(GROUP_BYTES);

  typedef enum logic {
    ST_RUN,
    ST_PENDING
  } state_e;

  state_e                 state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [PC_WIDTH-1:0]    pending_pc_q, pending_pc_d;
  logic [EPOCH_WIDTH-1:0] epoch_q, epoch_d;
  logic [CNT_WIDTH-1:0]   dec_cnt_q, dec_cnt_d;
  logic [CNT_WIDTH-1:0]   be_cnt_q, be_cnt_d;

  logic                   dec_valid;
  logic                   accept;
  logic [PC_WIDTH-1:0]    target;
  logic [PC_WIDTH-1:0]    seq_pc;

  // Redirect arbitration: backend wins; a decode redirect only counts if it
  // was raised by a group of the current epoch (older groups are wrong-path).
  always_comb begin
    dec_valid = decodeRedirect && (decodeRedirectEpoch == epoch_q);
    accept    = backendRecover || dec_valid;
    target    = backendRecover ? backendRecoverPC : decodeRedirectPC;
    seq_pc    = (pc_q & ~GROUP_MASK) + GROUP_STEP;
  end

  // Next-state logic for PC, pending target, FSM state, epoch and counters.
  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves one
    // unassigned, which would infer a latch.
    state_d      = state_q;
    pc_d         = pc_q;
    pending_pc_d = pending_pc_q;
    epoch_d      = epoch_q;
    dec_cnt_d    = dec_cnt_q;
    be_cnt_d     = be_cnt_q;

    case (state_q)
      ST_RUN: begin
        if (accept) begin
          if (!fetchStall) begin
            pc_d = target;
          end else begin
            pending_pc_d = target;
            state_d      = ST_PENDING;
          end
        end else if (!fetchStall) begin
          pc_d = predTaken ? predAddr : seq_pc;
        end
      end
      ST_PENDING: begin
        if (accept) begin
          pending_pc_d = target;
        end
        if (!fetchStall) begin
          pc_d    = accept ? target : pending_pc_q;
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase

    if (accept) begin
      epoch_d = epoch_q + EPOCH_WIDTH'(1);
      if (backendRecover) begin
        if (be_cnt_q != '1) be_cnt_d = be_cnt_q + CNT_WIDTH'(1);
      end else begin
        if (dec_cnt_q != '1) dec_cnt_d = dec_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_RUN;
      pc_q         <= RESET_PC;
      pending_pc_q <= '0;
      epoch_q      <= '0;
      dec_cnt_q    <= '0;
      be_cnt_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      state_q      <= state_d;
      pc_q         <= pc_d;
      pending_pc_q <= pending_pc_d;
      epoch_q      <= epoch_d;
      dec_cnt_q    <= dec_cnt_d;
      be_cnt_q     <= be_cnt_d;
    end
  end

  assign fetchPC           = pc_q;
  assign fetchEpoch        = epoch_q;
  assign fetchValid        = (state_q == ST_RUN) && !rst;
  assign redirectAccepted  = accept && !rst;
  assign decodeRedirectCnt = dec_cnt_q;
  assign backendRecoverCnt = be_cnt_q;

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Directed bench for fetch_redirect_unit. Inputs change on the falling edge;
// outputs are sampled 1 ns later, i.e. they show the current registered state
// plus the combinational redirectAccepted for the applied inputs.
module tb_fetch_redirect_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetchStall;
  logic        backendRecover;
  logic [31:0] backendRecoverPC;
  logic        decodeRedirect;
  logic [31:0] decodeRedirectPC;
  logic [1:0]  decodeRedirectEpoch;
  logic        predTaken;
  logic [31:0] predAddr;
  logic [31:0] fetchPC;
  logic        fetchValid;
  logic [1:0]  fetchEpoch;
  logic        redirectAccepted;
  logic [15:0] decodeRedirectCnt;
  logic [15:0] backendRecoverCnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fetch_redirect_unit dut (
    .clk                 (clk),
    .rst                 (rst),
    .fetchStall          (fetchStall),
    .backendRecover      (backendRecover),
    .backendRecoverPC    (backendRecoverPC),
    .decodeRedirect      (decodeRedirect),
    .decodeRedirectPC    (decodeRedirectPC),
    .decodeRedirectEpoch (decodeRedirectEpoch),
    .predTaken           (predTaken),
    .predAddr            (predAddr),
    .fetchPC             (fetchPC),
    .fetchValid          (fetchValid),
    .fetchEpoch          (fetchEpoch),
    .redirectAccepted    (redirectAccepted),
    .decodeRedirectCnt   (decodeRedirectCnt),
    .backendRecoverCnt   (backendRecoverCnt)
  );

  typedef struct {
    logic        stall;
    logic        br;
    logic [31:0] br_pc;
    logic        dr;
    logic [31:0] dr_pc;
    logic [1:0]  dr_ep;
    logic        pt;
    logic [31:0] pa;
    logic [31:0] e_pc;
    logic        e_v;
    logic [1:0]  e_ep;
    logic        e_ra;
    logic [15:0] e_dc;
    logic [15:0] e_bc;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic stall, logic br, logic [31:0] br_pc,
                              logic dr, logic [31:0] dr_pc, logic [1:0] dr_ep,
                              logic pt, logic [31:0] pa,
                              logic [31:0] e_pc, logic e_v, logic [1:0] e_ep,
                              logic e_ra, logic [15:0] e_dc, logic [15:0] e_bc);
    vec_t v;
    v.stall = stall; v.br = br; v.br_pc = br_pc;
    v.dr = dr; v.dr_pc = dr_pc; v.dr_ep = dr_ep;
    v.pt = pt; v.pa = pa;
    v.e_pc = e_pc; v.e_v = e_v; v.e_ep = e_ep; v.e_ra = e_ra;
    v.e_dc = e_dc; v.e_bc = e_bc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    fetchStall          = 1'b0;
    backendRecover      = 1'b0;
    backendRecoverPC    = '0;
    decodeRedirect      = 1'b0;
    decodeRedirectPC    = '0;
    decodeRedirectEpoch = '0;
    predTaken           = 1'b0;
    predAddr            = '0;
  endtask

  // Apply one vector at the falling edge, compare all outputs, then advance
  // past the next rising edge to the following falling edge.
  task automatic run_vec(input string tag, input vec_t v);
    fetchStall          = v.stall;
    backendRecover      = v.br;
    backendRecoverPC    = v.br_pc;
    decodeRedirect      = v.dr;
    decodeRedirectPC    = v.dr_pc;
    decodeRedirectEpoch = v.dr_ep;
    predTaken           = v.pt;
    predAddr            = v.pa;
    #1;
    check({tag, ".pc"},  fetchPC,                   v.e_pc);
    check({tag, ".v"},   32'(fetchValid),           32'(v.e_v));
    check({tag, ".ep"},  32'(fetchEpoch),           32'(v.e_ep));
    check({tag, ".ra"},  32'(redirectAccepted),     32'(v.e_ra));
    check({tag, ".dc"},  32'(decodeRedirectCnt),    32'(v.e_dc));
    check({tag, ".bc"},  32'(backendRecoverCnt),    32'(v.e_bc));
    @(negedge clk);
  endtask

  // Hold reset for two cycles, check reset outputs, release on a falling edge.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    drive_idle();
    repeat (2) @(negedge clk);
    #1;
    check({tag, ".rst_pc"}, fetchPC, 32'h0000_1000);
    check({tag, ".rst_v"},  32'(fetchValid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // Main table, starting right after reset release at epoch 0.
    //         stall br br_pc        dr dr_pc        ep pt pa            pc            v ep ra dc bc
    vq.push_back(mk(0, 0, 0,           0, 0,           0, 0, 0,            32'h0000_1000, 1, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0,           0, 0,           0, 0, 0,            32'h0000_1008, 1, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0,           0, 0,           0, 1, 32'h2004,     32'h0000_1010, 1, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0,           0, 0,           0, 0, 0,            32'h0000_2004, 1, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0,           0, 0,           0, 0, 0,            32'h0000_2008, 1, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0,           1, 32'h3000,    0, 0, 0,            32'h0000_2010, 1, 0, 1, 0, 0));
    vq.push_back(mk(0, 0, 0,           1, 32'h3000,    0, 0, 0,            32'h0000_3000, 1, 1, 0, 1, 0));
    vq.push_back(mk(0, 0, 0,           0, 0,           0, 0, 0,            32'h0000_3008, 1, 1, 0, 1, 0));
    vq.push_back(mk(0, 1, 32'h6000,    1, 32'h7000,    1, 1, 32'h9999,     32'h0000_3010, 1, 1, 1, 1, 0));
    vq.push_back(mk(0, 0, 0,           0, 0,           0, 0, 0,            32'h0000_6000, 1, 2, 0, 1, 1));
    vq.push_back(mk(0, 0, 0,           1, 32'h7000,    1, 0, 0,            32'h0000_6008, 1, 2, 0, 1, 1));
    vq.push_back(mk(0, 0, 0,           0, 0,           0, 1, 32'hFFFF_FFFC, 32'h0000_6010, 1, 2, 0, 1, 1));
    vq.push_back(mk(0, 0, 0,           0, 0,           0, 0, 0,            32'hFFFF_FFFC, 1, 2, 0, 1, 1));
    vq.push_back(mk(1, 0, 0,           0, 0,           0, 1, 32'h9000,     32'h0000_0000, 1, 2, 0, 1, 1));
    vq.push_back(mk(0, 0, 0,           0, 0,           0, 0, 0,            32'h0000_0000, 1, 2, 0, 1, 1));
    vq.push_back(mk(0, 0, 0,           0, 0,           0, 0, 0,            32'h0000_0008, 1, 2, 0, 1, 1));

    do_reset("r0");
    foreach (vq[i]) run_vec($sformatf("row%0d", i), vq[i]);

    // Redirects deferred across a three-cycle stall, then a new redirect on
    // the cycle the stall drops (overrides pending target, epoch wraps 3->0).
    do_reset("r1");
    run_vec("stl0", mk(1, 1, 32'h4000, 0, 0,        0, 0, 0, 32'h1000, 1, 0, 1, 0, 0));
    run_vec("stl1", mk(1, 0, 0,        1, 32'h5000, 1, 1, 32'h9000, 32'h1000, 0, 1, 1, 0, 1));
    run_vec("stl2", mk(1, 0, 0,        0, 0,        0, 0, 0, 32'h1000, 0, 2, 0, 1, 1));
    run_vec("stl3", mk(0, 0, 0,        0, 0,        0, 0, 0, 32'h1000, 0, 2, 0, 1, 1));
    run_vec("stl4", mk(0, 0, 0,        0, 0,        0, 0, 0, 32'h5000, 1, 2, 0, 1, 1));
    run_vec("stl5", mk(1, 1, 32'h8000, 0, 0,        0, 0, 0, 32'h5008, 1, 2, 1, 1, 1));
    run_vec("stl6", mk(0, 1, 32'hA000, 0, 0,        0, 0, 0, 32'h5008, 0, 3, 1, 1, 2));
    run_vec("stl7", mk(0, 0, 0,        0, 0,        0, 0, 0, 32'hA000, 1, 0, 0, 1, 3));

    // Asynchronous reset in the middle of PENDING.
    run_vec("pnd0", mk(1, 1, 32'hB000, 0, 0,        0, 0, 0, 32'hA008, 1, 0, 1, 1, 3));
    fetchStall     = 1'b1;
    backendRecover = 1'b1;
    backendRecoverPC = 32'hC000;
    #1;
    check("pnd1.v", 32'(fetchValid), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    check("arst.pc", fetchPC, 32'h0000_1000);
    check("arst.v",  32'(fetchValid), 32'd0);
    check("arst.ra", 32'(redirectAccepted), 32'd0);
    check("arst.ep", 32'(fetchEpoch), 32'd0);
    drive_idle();
    @(negedge clk);
    rst = 1'b0;
    run_vec("post0", mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h1000, 1, 0, 0, 0, 0));
    run_vec("post1", mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h1008, 1, 0, 0, 0, 0));

    // Counter saturation: 2^16+2 back-to-back backend recoveries.
    do_reset("r2");
    backendRecover   = 1'b1;
    backendRecoverPC = 32'h0000_C000;
    for (int i = 0; i < 65538; i++) begin
      #1;
      if (i == 3) check("sat.ep3", 32'(fetchEpoch), 32'd3);
      if (i == 4) check("sat.ep0", 32'(fetchEpoch), 32'd0);
      if (i == 65535) check("sat.bc_max", 32'(backendRecoverCnt), 32'h0000_FFFF);
      @(negedge clk);
    end
    #1;
    check("sat.bc", 32'(backendRecoverCnt), 32'h0000_FFFF);
    check("sat.dc", 32'(decodeRedirectCnt), 32'd0);
    check("sat.pc", fetchPC, 32'h0000_C000);
    check("sat.ep", 32'(fetchEpoch), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
